// File: rtl/inst_mem_pkg.sv
// Shared types and helpers for the instruction-memory server:
// FSM state encoding, the NOP word and the word-index width function.
package inst_mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam logic [31:0] NOP = 32'h0000_0000;

  function automatic int unsigned word_idx_w(input int unsigned depth);
    return (depth < 2) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/inst_mem_array.sv
// Instruction storage: synchronous write port, combinational read port.
// The caller registers the read data, so a same-edge write returns the old word.
module inst_mem_array
  import inst_mem_pkg::*;
#(
  parameter int unsigned DEPTH = 256,
  parameter int unsigned IW    = word_idx_w(DEPTH)
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [IW-1:0] waddr_i,
  input  logic [31:0]   wdata_i,
  input  logic [IW-1:0] raddr_i,
  output logic [31:0]   rdata_o
);

  logic [31:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/inst_mem_server.sv
// Single-outstanding instruction fetch server with fixed response latency.
// Optional macro INST_MEM_ALIGN_CHK_EN reports misaligned/out-of-range fetches on resp_err.
module inst_mem_server
  import inst_mem_pkg::*;
#(
  parameter int unsigned DEPTH   = 256,
  parameter int unsigned LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_inst,
  output logic        resp_err,
  input  logic        ld_en,
  input  logic [31:0] ld_addr,
  input  logic [31:0] ld_data
);

  localparam int unsigned IW       = word_idx_w(DEPTH);
  localparam logic [3:0]  CNT_INIT = 4'(LATENCY - 1);

  state_e        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [IW-1:0] idx_q;
  logic          oor_q;
  logic [31:0]   resp_inst_q;
  logic          resp_err_q;

  logic          hs;
  logic          enter_resp;
  logic [IW-1:0] req_idx, rd_idx;
  logic          req_oor, ld_oor, rd_oor;
  logic          mem_we;
  logic [31:0]   rdata;
  logic [31:0]   inst_d;
  logic          err_d;
  logic          unused_addr_bits;

  assign req_idx = req_addr[IW+1:2];
  assign req_oor = (req_addr >> (IW + 2)) != 32'd0;
  assign ld_oor  = (ld_addr >> (IW + 2)) != 32'd0;

  assign req_ready  = (state_q == IDLE);
  assign resp_valid = (state_q == RESP);
  assign resp_inst  = resp_inst_q;
  assign resp_err   = resp_err_q;
  assign hs         = req_valid && req_ready;

  // With LATENCY==1 RESP is entered on the accept edge, before idx_q is loaded.
  assign rd_idx = (state_q == IDLE) ? req_idx : idx_q;
  assign rd_oor = (state_q == IDLE) ? req_oor : oor_q;

  assign mem_we           = ld_en && !rst && !ld_oor;
  assign unused_addr_bits = ^{ld_addr[1:0], req_addr[1:0]};

  inst_mem_array #(
    .DEPTH (DEPTH),
    .IW    (IW)
  ) u_array (
    .clk     (clk),
    .we_i    (mem_we),
    .waddr_i (ld_addr[IW+1:2]),
    .wdata_i (ld_data),
    .raddr_i (rd_idx),
    .rdata_o (rdata)
  );

`ifdef INST_MEM_ALIGN_CHK_EN
  logic mis_q;
  logic rd_mis;

  assign rd_mis = (state_q == IDLE) ? (req_addr[1:0] != 2'b00) : mis_q;

  always_ff @(posedge clk) begin
    if (hs) begin
      mis_q <= (req_addr[1:0] != 2'b00);
    end
  end

  always_comb begin
    err_d  = rd_oor || rd_mis;
    inst_d = err_d ? NOP : rdata;
  end
`else
  always_comb begin
    err_d  = 1'b0;
    inst_d = rd_oor ? NOP : rdata;
  end
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (hs) begin
          cnt_d   = CNT_INIT;
          state_d = (LATENCY == 1) ? RESP : WAIT;
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) begin
          state_d = RESP;
        end
      end
      RESP: begin
        if (resp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign enter_resp = (state_d == RESP) && (state_q != RESP);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      resp_inst_q <= NOP;
      resp_err_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (enter_resp) begin
        resp_inst_q <= inst_d;
        resp_err_q  <= err_d;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (hs) begin
      idx_q <= req_idx;
      oor_q <= req_oor;
    end
  end

endmodule
